key_debouncer: RTL

//  Conditions the board's raw active-low push-buttons for synchronous logic.
//  Per key: synchronise, debounce, emit a clean active-high level and one-cycle press/release pulses.

---
 rtl/key_pkg.sv | 27 ++
 rtl/key_debounce_channel.sv | 153 +++++++++++++++
 rtl/key_debouncer.sv | 44 ++++
 3 files changed

// File: rtl/key_pkg.sv
// ============================================================================
// Module      : key_pkg
// Description : Shared FSM state encoding and ms-to-cycle helper for the key debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package key_pkg;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_state_t;

  // Clamped to one cycle so a very slow clock still gets a valid window.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    int cyc;
    cyc = (clk_hz / 1000) * ms;
    if (cyc < 1) cyc = 1;
    return cyc;
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce_channel.sv
// ============================================================================
// Module      : key_debounce_channel
// Description : One key: 2-flop synchroniser, debounce FSM, level and pulse outputs.
//               Optional auto-repeat enabled by KEY_DEBOUNCER_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce_channel
  import key_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_PER_MS = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic key,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int c_db = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int c_cw = $clog2(c_db + 1);
  localparam logic [c_cw-1:0] c_db_last = c_cw'(c_db - 1);
  localparam logic [c_cw-1:0] c_cnt_one = c_cw'(1);
  localparam int c_rd = ms_to_cycles(CLK_HZ, REPEAT_DLY_MS);
  localparam int c_rp = ms_to_cycles(CLK_HZ, REPEAT_PER_MS);

  logic            r_sync1, r_sync2;
  key_state_t      r_state, w_state_nxt;
  logic [c_cw-1:0] r_cnt, w_cnt_nxt;
  logic            r_level, w_level_nxt;
  logic            r_press, w_press_nxt;
  logic            r_release, w_release_nxt;
  logic            w_s;
  logic            w_rpt_pulse;

  assign w_s = ~r_sync2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1   <= key;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt | w_rpt_pulse;
      r_release <= w_release_nxt;
    end
  end

  // Any disagreement with the pending level restarts the full window.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_s) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!w_s) begin
          w_state_nxt = RELEASED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_db_last) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b1;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (w_s) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_db_last) begin
          w_state_nxt   = RELEASED;
          w_cnt_nxt     = '0;
          w_level_nxt   = 1'b0;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int c_rw = $clog2(c_rd + 1);
  localparam logic [c_rw-1:0] c_rd_last   = c_rw'(c_rd - 1);
  // Reloading to RD-RP makes every later pulse RP cycles apart.
  localparam logic [c_rw-1:0] c_rd_reload = c_rw'((c_rd > c_rp) ? (c_rd - c_rp) : 0);
  localparam logic [c_rw-1:0] c_rcnt_one  = c_rw'(1);

  logic [c_rw-1:0] r_rcnt, w_rcnt_nxt;
  logic            w_in_hold;

  assign w_in_hold   = (r_state == HELD) && w_s;
  assign w_rpt_pulse = w_in_hold && (r_rcnt == c_rd_last);

  always_comb begin
    w_rcnt_nxt = '0;
    if (w_in_hold) begin
      if (r_rcnt == c_rd_last) w_rcnt_nxt = c_rd_reload;
      else                     w_rcnt_nxt = r_rcnt + c_rcnt_one;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rcnt <= '0;
    else          r_rcnt <= w_rcnt_nxt;
  end
`else
  logic w_unused_rpt;
  assign w_unused_rpt = ^{c_rd, c_rp};
  assign w_rpt_pulse  = 1'b0;
`endif

  assign key_level   = r_level;
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// Module      : key_debouncer
// Description : N_KEYS independent debounced key channels for active-low buttons.
//               Auto-repeat on held keys when KEY_DEBOUNCER_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debouncer
  import key_pkg::*;
#(
  parameter int N_KEYS        = 4,
  parameter int CLK_HZ        = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int REPEAT_DLY_MS = 500,
  parameter int REPEAT_PER_MS = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release
);

  for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
    key_debounce_channel #(
      .CLK_HZ        (CLK_HZ),
      .DEBOUNCE_MS   (DEBOUNCE_MS),
      .REPEAT_DLY_MS (REPEAT_DLY_MS),
      .REPEAT_PER_MS (REPEAT_PER_MS)
    ) u_chan (
      .clk         (clk),
      .reset_n     (reset_n),
      .key         (key[gi]),
      .key_level   (key_level[gi]),
      .key_press   (key_press[gi]),
      .key_release (key_release[gi])
    );
  end

endmodule

`default_nettype wire
